univ_shift_reg_framed: RTL and testbench
========================================

Name: univ_shift_reg_framed

Overview:
- Parametrised universal shift register for the SHIFT_REGISTERS family: hold, shift right, shift left and parallel load, with serial in/out at both ends.
- Adds SIPO word framing. A bit counter tracks shifts in the current direction. After WIDTH consecutive same-direction shifts, the assembled word is captured into an output register and flagged with a one-cycle valid pulse.
- Used as the serial-to-parallel front end for byte/word-oriented receivers. Also usable as a PISO, via parallel load followed by shifting.

Parameters:
- WIDTH, 8: register and word width in bits; legal range 2..32.
- REVERSE_OUT, 0: 1 = captured word is bit-reversed (word[i] = q[WIDTH-1-i]); 0 = word equals q.
- RESET_VAL, 0: reset value of q (WIDTH bits).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  clock enable; 0 = full hold of all state, word_valid forced 0.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sin_r  input  1  serial input entering at MSB on shift right.
- sin_l  input  1  serial input entering at LSB on shift left.
- pdata  input  WIDTH  parallel load data.
- q  output  WIDTH  live register contents.
- sout_r  output  1  q[0]; bit leaving on shift right.
- sout_l  output  1  q[WIDTH-1]; bit leaving on shift left.
- word  output  WIDTH  last captured frame, held until the next capture.
- word_valid  output  1  one-cycle pulse; word updated this cycle.
- bit_cnt  output  clog2(WIDTH+1)  shifts accumulated in the current frame (0..WIDTH-1).

Behaviour:
- Reset (clk edge with reset=1): q=RESET_VAL, word=0, word_valid=0, bit_cnt=0, last_dir=none. Reset has priority over en and mode. Reset mid-frame discards the partial frame.
- All outputs are registered. sout_r/sout_l are combinational taps of q.
- en=0: q, word, bit_cnt and last_dir hold; word_valid=0.
- en=1, mode 00: hold q and bit_cnt; word_valid=0.
- en=1, mode 01: q <= {sin_r, q[WIDTH-1:1]}.
- en=1, mode 10: q <= {q[WIDTH-2:0], sin_l}.
- en=1, mode 11: q <= pdata; bit_cnt <= 0; last_dir <= none; word_valid=0. A load never produces a capture.
- Frame counting on each shift (mode 01/10):
  - If the direction differs from last_dir (including none), the frame restarts: this shift counts as 1, so bit_cnt <= 1.
  - Otherwise bit_cnt increments.
  - last_dir <= current direction.
- Capture: when the shift brings the count to WIDTH (same direction, bit_cnt was WIDTH-1):
  - word <= post-shift q, bit-reversed if REVERSE_OUT=1.
  - word_valid <= 1 for that single cycle.
  - bit_cnt <= 0; last_dir is kept, so back-to-back frames stream with no gap.
- Continuous streaming: with en=1 and a fixed direction, word_valid pulses exactly every WIDTH cycles.
- Edge cases:
  - Direction change on the cycle that would have completed a frame: no capture; bit_cnt <= 1.
  - en dropping mid-frame pauses the count; the frame resumes when en returns.
  - word_valid is never high for two consecutive cycles when WIDTH >= 2.

Test Plan:
- WIDTH=4, after reset, mode=01, sin_r=1,0,1,1 on 4 cycles -> q=1000,0100,1010,1101. After the 4th edge: word=1101, word_valid=1 for one cycle, bit_cnt=0.
- Same stimulus with REVERSE_OUT=1 -> word=1011; q is unaffected (1101).
- WIDTH=4, mode=10, sin_l=1,1,0,1 -> q=0001,0011,0110,1101; word=1101 with a pulse. Continue 4 more shifts of 0 -> second pulse exactly 4 cycles later, word=0000.
- Load pdata=1010 then mode=01, sin_r=0 -> q=0101, sout_r=1, bit_cnt=1, no word_valid. 2 right shifts then 1 left shift -> bit_cnt=1, no capture.
- Mid-frame pause and reset: 2 right shifts, en=0 for 3 cycles -> q and bit_cnt=2 held, word_valid=0. Then 2 more shifts -> capture. Then reset asserted after 3 shifts -> q=RESET_VAL, bit_cnt=0, word=0, word_valid=0.
- mode=00 with en=1 for 5 cycles mid-frame -> q and bit_cnt unchanged, no pulse. sout_l tracks q[3] throughout.

Source files
------------

// File: rtl/univ_shift_reg_framed.sv
// rtl/univ_shift_reg_framed.sv - universal shift register with SIPO word framing
//
// Purpose: hold / shift right / shift left / parallel load register with
// serial taps at both ends. Consecutive shifts in one direction are counted;
// every WIDTH of them the assembled word is captured into a held output
// register and flagged with a one-cycle pulse.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   en         in   1      clock enable (0 = hold everything, no pulse)
//   mode       in   2      00 hold, 01 shift right, 10 shift left, 11 load
//   sin_r      in   1      bit entering at MSB on shift right
//   sin_l      in   1      bit entering at LSB on shift left
//   pdata      in   WIDTH  parallel load data
//   q          out  WIDTH  live register contents
//   sout_r     out  1      q[0]
//   sout_l     out  1      q[WIDTH-1]
//   word       out  WIDTH  last captured frame
//   word_valid out  1      one-cycle pulse when word is updated
//   bit_cnt    out  CW     shifts accumulated in the current frame

module univ_shift_reg_framed #(
    parameter int               WIDTH       = 8,
    parameter bit               REVERSE_OUT = 1'b0,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0,
    localparam int              CW          = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    output logic [CW-1:0]    bit_cnt
);

    typedef enum logic [1:0] {
        DIR_NONE  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10
    } dir_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_word;
    logic             r_word_valid;
    logic [CW-1:0]    r_cnt;
    dir_t             r_last_dir;

    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_q_rev;
    logic [WIDTH-1:0] w_word_next;
    dir_t             w_shift_dir;
    logic             w_is_shift;
    logic             w_same_dir;
    logic             w_frame_done;

    always_comb begin
        w_q_next    = r_q;
        w_shift_dir = DIR_NONE;
        case (mode)
            2'b01: begin
                w_q_next    = {sin_r, r_q[WIDTH-1:1]};
                w_shift_dir = DIR_RIGHT;
            end
            2'b10: begin
                w_q_next    = {r_q[WIDTH-2:0], sin_l};
                w_shift_dir = DIR_LEFT;
            end
            2'b11: begin
                w_q_next = pdata;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        w_q_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_q_rev[i] = w_q_next[WIDTH-1-i];
        end
    end

    assign w_word_next  = REVERSE_OUT ? w_q_rev : w_q_next;
    assign w_is_shift   = (w_shift_dir != DIR_NONE);
    // A shift continues the frame only if it matches the previous shift's
    // direction; DIR_NONE after reset/load never matches, forcing a restart.
    assign w_same_dir   = w_is_shift && (w_shift_dir == r_last_dir);
    assign w_frame_done = w_same_dir && (r_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q          <= RESET_VAL;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_cnt        <= '0;
            r_last_dir   <= DIR_NONE;
        end else begin
            r_word_valid <= 1'b0;
            if (en) begin
                r_q <= w_q_next;
                if (mode == 2'b11) begin
                    r_cnt      <= '0;
                    r_last_dir <= DIR_NONE;
                end else if (w_is_shift) begin
                    r_last_dir <= w_shift_dir;
                    if (!w_same_dir) begin
                        r_cnt <= CW'(1);
                    end else if (w_frame_done) begin
                        // Direction is kept so the next shift extends a fresh
                        // frame with no gap cycle.
                        r_cnt        <= '0;
                        r_word       <= w_word_next;
                        r_word_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            end
        end
    end

    assign q          = r_q;
    assign sout_r     = r_q[0];
    assign sout_l     = r_q[WIDTH-1];
    assign word       = r_word;
    assign word_valid = r_word_valid;
    assign bit_cnt    = r_cnt;

endmodule

// File: tb/tb_univ_shift_reg_framed.sv
// tb/tb_univ_shift_reg_framed.sv - scoreboard bench for univ_shift_reg_framed

module tb_univ_shift_reg_framed;

    localparam int W  = 4;
    localparam int CW = 3;

    typedef struct {
        logic [W-1:0]  q;
        logic [CW-1:0] cnt;
        logic          v;
        logic [W-1:0]  w;
        logic [W-1:0]  wr;
        logic          chk_rq;
        logic [W-1:0]  rq;
    } snap_t;

    typedef struct {
        logic [W-1:0] w;
        logic [W-1:0] wr;
    } word_t;

    logic          clk = 1'b0;
    logic          reset, en, sin_r, sin_l;
    logic [1:0]    mode;
    logic [W-1:0]  pdata;

    logic [W-1:0]  q, word, q_r, word_r;
    logic          sout_r, sout_l, word_valid, sout_r_r, sout_l_r, word_valid_r;
    logic [CW-1:0] bit_cnt, bit_cnt_r;

    snap_t snap_q[$];
    word_t word_q[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    univ_shift_reg_framed #(.WIDTH(W), .REVERSE_OUT(1'b0), .RESET_VAL(4'b0000)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
        .pdata(pdata), .q(q), .sout_r(sout_r), .sout_l(sout_l), .word(word),
        .word_valid(word_valid), .bit_cnt(bit_cnt)
    );

    univ_shift_reg_framed #(.WIDTH(W), .REVERSE_OUT(1'b1), .RESET_VAL(4'b1001)) dut_rev (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .sin_r(sin_r), .sin_l(sin_l),
        .pdata(pdata), .q(q_r), .sout_r(sout_r_r), .sout_l(sout_l_r), .word(word_r),
        .word_valid(word_valid_r), .bit_cnt(bit_cnt_r)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue the state expected after the edge.
    task automatic step(input logic rst, input logic e, input logic [1:0] m,
                        input logic sr, input logic sl, input logic [W-1:0] pd,
                        input logic [W-1:0] eq, input logic [CW-1:0] ec, input logic ev,
                        input logic [W-1:0] ew, input logic [W-1:0] ewr,
                        input logic crq, input logic [W-1:0] erq);
        snap_t s;
        word_t wd;
        @(negedge clk);
        reset = rst; en = e; mode = m; sin_r = sr; sin_l = sl; pdata = pd;
        s.q = eq; s.cnt = ec; s.v = ev; s.w = ew; s.wr = ewr; s.chk_rq = crq; s.rq = erq;
        snap_q.push_back(s);
        if (ev) begin
            wd.w = ew; wd.wr = ewr;
            word_q.push_back(wd);
        end
    endtask

    always @(posedge clk) begin
        snap_t s;
        word_t wd;
        #1;
        if (snap_q.size() > 0) begin
            s = snap_q.pop_front();
            chk("q", 32'(q), 32'(s.q));
            chk("bit_cnt", 32'(bit_cnt), 32'(s.cnt));
            chk("word_valid", 32'(word_valid), 32'(s.v));
            chk("word", 32'(word), 32'(s.w));
            chk("sout_r", 32'(sout_r), 32'(s.q[0]));
            chk("sout_l", 32'(sout_l), 32'(s.q[W-1]));
            chk("rev_word_valid", 32'(word_valid_r), 32'(s.v));
            chk("rev_bit_cnt", 32'(bit_cnt_r), 32'(s.cnt));
            chk("rev_word", 32'(word_r), 32'(s.wr));
            if (s.chk_rq) chk("rev_q_reset", 32'(q_r), 32'(s.rq));
        end
        if (word_valid) begin
            if (word_q.size() == 0) begin
                chk("unexpected_word_valid", 32'(word_valid), 32'(0));
            end else begin
                wd = word_q.pop_front();
                chk("captured_word", 32'(word), 32'(wd.w));
                chk("captured_word_rev", 32'(word_r), 32'(wd.wr));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset = 1'b1; en = 1'b0; mode = 2'b00; sin_r = 1'b0; sin_l = 1'b0; pdata = '0;
        //   rst en mode  sr sl pd       q        cnt v  word     wrev     crq rq
        // Right-shift frame 1,0,1,1
        step(1, 0, 2'b00, 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 4'b1001);
        step(0, 1, 2'b01, 1, 0, 4'b0000, 4'b1000, 1, 0, 4'b0000, 4'b0000, 0, 4'b0000);
        step(0, 1, 2'b01, 0, 0, 4'b0000, 4'b0100, 2, 0, 4'b0000, 4'b0000, 0, 4'b0000);
        step(0, 1, 2'b01, 1, 0, 4'b0000, 4'b1010, 3, 0, 4'b0000, 4'b0000, 0, 4'b0000);
        step(0, 1, 2'b01, 1, 0, 4'b0000, 4'b1101, 0, 1, 4'b1101, 4'b1011, 1, 4'b1101);
        step(0, 1, 2'b00, 0, 0, 4'b0000, 4'b1101, 0, 0, 4'b1101, 4'b1011, 0, 4'b0000);
        // Left-shift frame 1,1,0,1 then four zeros streaming
        step(1, 1, 2'b10, 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 4'b1001);
        step(0, 1, 2'b10, 0, 1, 4'b0000, 4'b0001, 1, 0, 4'b0000, 4'b0000, 0, 4'b0000);
        step(0, 1, 2'b10, 0, 1, 4'b0000, 4'b0011, 2, 0, 4'b0000, 4'b0000, 0, 4'b0000);
        step(0, 1, 2'b10, 0, 0, 4'b0000, 4'b0110, 3, 0, 4'b0000, 4'b0000, 0, 4'b0000);
        step(0, 1, 2'b10, 0, 1, 4'b0000, 4'b1101, 0, 1, 4'b1101, 4'b1011, 0, 4'b0000);
        step(0, 1, 2'b10, 0, 0, 4'b0000, 4'b1010, 1, 0, 4'b1101, 4'b1011, 0, 4'b0000);
        step(0, 1, 2'b10, 0, 0, 4'b0000, 4'b0100, 2, 0, 4'b1101, 4'b1011, 0, 4'b0000);
        step(0, 1, 2'b10, 0, 0, 4'b0000, 4'b1000, 3, 0, 4'b1101, 4'b1011, 0, 4'b0000);
        step(0, 1, 2'b10, 0, 0, 4'b0000, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0, 4'b0000);
        // Load, right shifts, direction change where a frame would complete
        step(0, 1, 2'b11, 0, 0, 4'b1010, 4'b1010, 0, 0, 4'b0000, 4'b0000, 1, 4'b1010);
        step(0, 1, 2'b01, 0, 0, 4'b0000, 4'b0101, 1, 0, 4'b0000, 4'b0000, 0, 4'b0000);
        step(0, 1, 2'b01, 0, 0, 4'b0000, 4'b0010, 2, 0, 4'b0000, 4'b0000, 0, 4'b0000);
        step(0, 1, 2'b01, 0, 0, 4'b0000, 4'b0001, 3, 0, 4'b0000, 4'b0000, 0, 4'b0000);
        step(0, 1, 2'b10, 0, 0, 4'b0000, 4'b0010, 1, 0, 4'b0000, 4'b0000, 0, 4'b0000);
        // Pause with en=0 mid-frame, resume, then reset mid-frame
        step(1, 1, 2'b01, 0, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 4'b1001);
        step(0, 1, 2'b01, 1, 0, 4'b0000, 4'b1000, 1, 0, 4'b0000, 4'b0000, 0, 4'b0000);
        step(0, 1, 2'b01, 1, 0, 4'b0000, 4'b1100, 2, 0, 4'b0000, 4'b0000, 0, 4'b0000);
        step(0, 0, 2'b01, 0, 0, 4'b0000, 4'b1100, 2, 0, 4'b0000, 4'b0000, 0, 4'b0000);
        step(0, 0, 2'b11, 0, 0, 4'b1111, 4'b1100, 2, 0, 4'b0000, 4'b0000, 0, 4'b0000);
        step(0, 0, 2'b10, 0, 1, 4'b0000, 4'b1100, 2, 0, 4'b0000, 4'b0000, 0, 4'b0000);
        step(0, 1, 2'b01, 0, 0, 4'b0000, 4'b0110, 3, 0, 4'b0000, 4'b0000, 0, 4'b0000);
        step(0, 1, 2'b01, 1, 0, 4'b0000, 4'b1011, 0, 1, 4'b1011, 4'b1101, 0, 4'b0000);
        step(0, 1, 2'b01, 0, 0, 4'b0000, 4'b0101, 1, 0, 4'b1011, 4'b1101, 0, 4'b0000);
        step(0, 1, 2'b01, 0, 0, 4'b0000, 4'b0010, 2, 0, 4'b1011, 4'b1101, 0, 4'b0000);
        step(0, 1, 2'b01, 1, 0, 4'b0000, 4'b1001, 3, 0, 4'b1011, 4'b1101, 0, 4'b0000);
        step(1, 1, 2'b01, 1, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 1, 4'b1001);
        // Hold mode mid-frame keeps q and count, frame then completes
        step(0, 1, 2'b01, 1, 0, 4'b0000, 4'b1000, 1, 0, 4'b0000, 4'b0000, 0, 4'b0000);
        step(0, 1, 2'b01, 1, 0, 4'b0000, 4'b1100, 2, 0, 4'b0000, 4'b0000, 0, 4'b0000);
        step(0, 1, 2'b01, 1, 0, 4'b0000, 4'b1110, 3, 0, 4'b0000, 4'b0000, 0, 4'b0000);
        for (int i = 0; i < 5; i++)
            step(0, 1, 2'b00, 0, 1, 4'b0101, 4'b1110, 3, 0, 4'b0000, 4'b0000, 0, 4'b0000);
        step(0, 1, 2'b01, 0, 0, 4'b0000, 4'b0111, 0, 1, 4'b0111, 4'b1110, 0, 4'b0000);
        // Load mid-frame restarts the frame
        step(0, 1, 2'b01, 1, 0, 4'b0000, 4'b1011, 1, 0, 4'b0111, 4'b1110, 0, 4'b0000);
        step(0, 1, 2'b11, 0, 0, 4'b0110, 4'b0110, 0, 0, 4'b0111, 4'b1110, 0, 4'b0000);
        step(0, 1, 2'b01, 1, 0, 4'b0000, 4'b1011, 1, 0, 4'b0111, 4'b1110, 0, 4'b0000);
        step(0, 1, 2'b01, 0, 0, 4'b0000, 4'b0101, 2, 0, 4'b0111, 4'b1110, 0, 4'b0000);
        step(0, 1, 2'b01, 0, 0, 4'b0000, 4'b0010, 3, 0, 4'b0111, 4'b1110, 0, 4'b0000);
        step(0, 1, 2'b01, 0, 0, 4'b0000, 4'b0001, 0, 1, 4'b0001, 4'b1000, 0, 4'b0000);
        step(0, 1, 2'b00, 0, 0, 4'b0000, 4'b0001, 0, 0, 4'b0001, 4'b1000, 0, 4'b0000);

        t = 0;
        while (snap_q.size() > 0 && t < 20) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        chk("scoreboard_drained", 32'(snap_q.size()), 32'(0));
        chk("word_queue_drained", 32'(word_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
